clock_ctrl: RTL and testbench

CLOCK_CTRL -- requirements
Module: clock_ctrl

---
 rtl/clock_ctrl.sv | 149 ++++++++++++++
 tb/tb_clock_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_ctrl.sv
// clock_ctrl: hours/minutes/seconds time-of-day counter with a
// three-state mode FSM for setting the time from two push buttons.
// Seconds, minutes and hours advance on the one-per-second tick while
// in RUN. SET_HOUR and SET_MIN freeze time and let btn_inc step a field.
// Every output is taken directly from a flop.

module clock_ctrl #(
  parameter int SEC_MAX  = 59,
  parameter int MIN_MAX  = 59,
  parameter int HOUR_MAX = 23
) (
  input  logic                          clk,
  input  logic                          res_n,
  input  logic                          tick,
  input  logic                          btn_mode,
  input  logic                          btn_inc,
  output logic [$clog2(SEC_MAX+1)-1:0]  sec,
  output logic [$clog2(MIN_MAX+1)-1:0]  min,
  output logic [$clog2(HOUR_MAX+1)-1:0] hour,
  output logic [1:0]                    mode,
  output logic                          day_cy
);

  localparam int SW = $clog2(SEC_MAX + 1);
  localparam int MW = $clog2(MIN_MAX + 1);
  localparam int HW = $clog2(HOUR_MAX + 1);

  localparam logic [SW-1:0] SEC_TOP  = SW'(SEC_MAX);
  localparam logic [MW-1:0] MIN_TOP  = MW'(MIN_MAX);
  localparam logic [HW-1:0] HOUR_TOP = HW'(HOUR_MAX);

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2
  } mode_e;

  mode_e         mode_q, mode_d;
  logic [SW-1:0] sec_q, sec_d;
  logic [MW-1:0] min_q, min_d;
  logic [HW-1:0] hour_q, hour_d;
  logic          day_cy_q, day_cy_d;
  logic          btn_mode_prev_q, btn_mode_prev_d;
  logic          btn_inc_prev_q, btn_inc_prev_d;

  logic          mode_press;
  logic          inc_press;
  logic          sec_wrap;
  logic          min_wrap;
  logic          hour_wrap;
  logic [SW-1:0] sec_next;
  logic [MW-1:0] min_next;
  logic [HW-1:0] hour_next;

  // Press detection and the wrapping successor of each field; the >= keeps
  // a field from ever climbing past its terminal count.
  always_comb begin
    mode_press = btn_mode & ~btn_mode_prev_q;
    inc_press  = btn_inc & ~btn_inc_prev_q;
    sec_wrap   = (sec_q >= SEC_TOP);
    min_wrap   = (min_q >= MIN_TOP);
    hour_wrap  = (hour_q >= HOUR_TOP);
    sec_next   = sec_wrap  ? '0 : sec_q + SW'(1);
    min_next   = min_wrap  ? '0 : min_q + MW'(1);
    hour_next  = hour_wrap ? '0 : hour_q + HW'(1);
  end

  // Next-state logic: mode FSM, time counting with carries, and button edits.
  always_comb begin
    mode_d          = mode_q;
    sec_d           = sec_q;
    min_d           = min_q;
    hour_d          = hour_q;
    day_cy_d        = 1'b0;
    btn_mode_prev_d = btn_mode;
    btn_inc_prev_d  = btn_inc;

    case (mode_q)
      MODE_RUN: begin
        // The tick is honoured even on the cycle the mode button leaves RUN.
        if (tick) begin
          sec_d = sec_next;
          if (sec_wrap) begin
            min_d = min_next;
            if (min_wrap) begin
              hour_d   = hour_next;
              day_cy_d = hour_wrap;
            end
          end
        end
        if (mode_press) begin
          mode_d = MODE_SET_HOUR;
        end
      end

      MODE_SET_HOUR: begin
        // A mode press wins over a simultaneous increment press.
        if (mode_press) begin
          mode_d = MODE_SET_MIN;
        end else if (inc_press) begin
          hour_d = hour_next;
        end
      end

      MODE_SET_MIN: begin
        // Leaving set mode restarts the minute at second zero.
        if (mode_press) begin
          mode_d = MODE_RUN;
          sec_d  = '0;
        end else if (inc_press) begin
          min_d = min_next;
        end
      end

      default: begin
        mode_d = MODE_RUN;
      end
    endcase
  end

  // State register; the previous button levels reset high so that a button
  // held through reset release is not seen as a press.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      mode_q          <= MODE_RUN;
      sec_q           <= '0;
      min_q           <= '0;
      hour_q          <= '0;
      day_cy_q        <= 1'b0;
      btn_mode_prev_q <= 1'b1;
      btn_inc_prev_q  <= 1'b1;
    end else begin
      mode_q          <= mode_d;
      sec_q           <= sec_d;
      min_q           <= min_d;
      hour_q          <= hour_d;
      day_cy_q        <= day_cy_d;
      btn_mode_prev_q <= btn_mode_prev_d;
      btn_inc_prev_q  <= btn_inc_prev_d;
    end
  end

  assign sec    = sec_q;
  assign min    = min_q;
  assign hour   = hour_q;
  assign mode   = mode_q;
  assign day_cy = day_cy_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// tb_clock_ctrl: directed test of clock_ctrl against a time-of-day model
// that treats the clock as seconds-since-midnight.

module tb_clock_ctrl;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;
  localparam int SEC_PER_MIN  = SEC_MAX + 1;
  localparam int SEC_PER_HOUR = (MIN_MAX + 1) * SEC_PER_MIN;
  localparam int SEC_PER_DAY  = (HOUR_MAX + 1) * SEC_PER_HOUR;

  logic       clk      = 1'b0;
  logic       res_n    = 1'b0;
  logic       tick     = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc  = 1'b0;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic [1:0] mode;
  logic       day_cy;

  int total     = 0;
  int bad       = 0;
  int day_count = 0;
  int day_base  = 0;

  int   m_sec       = 0;
  int   m_min       = 0;
  int   m_hour      = 0;
  int   m_mode      = 0;
  int   m_day       = 0;
  logic m_prev_mode = 1'b1;
  logic m_prev_inc  = 1'b1;

  clock_ctrl #(
    .SEC_MAX (SEC_MAX),
    .MIN_MAX (MIN_MAX),
    .HOUR_MAX(HOUR_MAX)
  ) dut (
    .clk     (clk),
    .res_n   (res_n),
    .tick    (tick),
    .btn_mode(btn_mode),
    .btn_inc (btn_inc),
    .sec     (sec),
    .min     (min),
    .hour    (hour),
    .mode    (mode),
    .day_cy  (day_cy)
  );

  // 10-unit clock period.
  always #5 clk = ~clk;

  // Reference model: time kept as seconds of the day, modes as small integers.
  always @(posedge clk or negedge res_n) begin : model
    int   t;
    logic mp;
    logic ip;
    if (!res_n) begin
      m_sec       = 0;
      m_min       = 0;
      m_hour      = 0;
      m_mode      = 0;
      m_day       = 0;
      m_prev_mode = 1'b1;
      m_prev_inc  = 1'b1;
    end else begin
      mp    = btn_mode && !m_prev_mode;
      ip    = btn_inc && !m_prev_inc;
      m_day = 0;
      if (m_mode == 0) begin
        if (tick) begin
          t = m_hour * SEC_PER_HOUR + m_min * SEC_PER_MIN + m_sec;
          t = (t + 1) % SEC_PER_DAY;
          if (t == 0) m_day = 1;
          m_hour = t / SEC_PER_HOUR;
          m_min  = (t % SEC_PER_HOUR) / SEC_PER_MIN;
          m_sec  = t % SEC_PER_MIN;
        end
        if (mp) m_mode = 1;
      end else if (m_mode == 1) begin
        if (mp) m_mode = 2;
        else if (ip) m_hour = (m_hour + 1) % (HOUR_MAX + 1);
      end else begin
        if (mp) begin
          m_mode = 0;
          m_sec  = 0;
        end else if (ip) begin
          m_min = (m_min + 1) % (MIN_MAX + 1);
        end
      end
      m_prev_mode = btn_mode;
      m_prev_inc  = btn_inc;
    end
  end

  // Counts the clock cycles on which day_cy is seen high.
  always @(negedge clk) begin
    if (day_cy === 1'b1) day_count++;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic compareModel();
    checkOutput("cyc_sec", 32'(sec), 32'(m_sec));
    checkOutput("cyc_min", 32'(min), 32'(m_min));
    checkOutput("cyc_hour", 32'(hour), 32'(m_hour));
    checkOutput("cyc_mode", 32'(mode), 32'(m_mode));
    checkOutput("cyc_day_cy", 32'(day_cy), 32'(m_day));
  endtask

  task automatic applyStimulus(input logic t, input logic bm, input logic bi);
    tick     = t;
    btn_mode = bm;
    btn_inc  = bi;
    @(negedge clk);
    compareModel();
  endtask

  task automatic pressMode();
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic pressInc();
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic tickN(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic markDay();
    applyStimulus(1'b0, 1'b0, 1'b0);
    day_base = day_count;
  endtask

  task automatic checkDay(input string name, input int expected);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput(name, 32'(day_count - day_base), 32'(expected));
  endtask

  initial begin
    // Reset state.
    res_n = 1'b0;
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("rst_sec", 32'(sec), 32'd0);
    checkOutput("rst_mode", 32'(mode), 32'd0);
    checkOutput("rst_day_cy", 32'(day_cy), 32'd0);
    res_n = 1'b1;
    markDay();

    // 61 ticks in RUN: 00:01:01, no day carry.
    tickN(61);
    checkOutput("run61_sec", 32'(sec), 32'd1);
    checkOutput("run61_min", 32'(min), 32'd1);
    checkOutput("run61_hour", 32'(hour), 32'd0);
    checkDay("run61_day_cy", 0);

    // Set 23:59 through the buttons, return to RUN, roll over the day.
    pressMode();
    checkOutput("set_hour_mode", 32'(mode), 32'd1);
    repeat (23) pressInc();
    checkOutput("set_hour23", 32'(hour), 32'd23);
    pressMode();
    checkOutput("set_min_mode", 32'(mode), 32'd2);
    repeat (58) pressInc();
    checkOutput("set_min59", 32'(min), 32'd59);
    checkOutput("set_min59_hour", 32'(hour), 32'd23);
    pressMode();
    checkOutput("back_run_mode", 32'(mode), 32'd0);
    checkOutput("back_run_sec", 32'(sec), 32'd0);
    markDay();
    tickN(60);
    checkOutput("wrap_sec", 32'(sec), 32'd0);
    checkOutput("wrap_min", 32'(min), 32'd0);
    checkOutput("wrap_hour", 32'(hour), 32'd0);
    checkDay("wrap_day_cy_once", 1);

    // Mode and increment rising together in RUN: mode step only.
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("both_mode", 32'(mode), 32'd1);
    checkOutput("both_hour", 32'(hour), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // 25 hour increments with ticks running: hour wraps to 1, time frozen.
    for (int i = 0; i < 25; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0);
    end
    checkOutput("inc25_hour", 32'(hour), 32'd1);
    checkOutput("inc25_min", 32'(min), 32'd0);
    checkOutput("inc25_sec", 32'(sec), 32'd0);

    // Hold btn_inc for 100 cycles in SET_MIN: a single increment.
    pressMode();
    repeat (29) pressInc();
    repeat (100) applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("hold_min", 32'(min), 32'd30);
    checkOutput("hold_mode", 32'(mode), 32'd2);

    // Asynchronous reset between clock edges while in SET_MIN.
    #2 res_n = 1'b0;
    #1;
    checkOutput("async_min", 32'(min), 32'd0);
    checkOutput("async_hour", 32'(hour), 32'd0);
    checkOutput("async_mode", 32'(mode), 32'd0);
    @(negedge clk);
    compareModel();

    // btn_mode held through reset release is not a press.
    applyStimulus(1'b0, 1'b1, 1'b0);
    res_n = 1'b1;
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("held_mode", 32'(mode), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Tick together with the RUN->SET_HOUR press is still applied.
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("tick_leave_sec", 32'(sec), 32'd1);
    checkOutput("tick_leave_mode", 32'(mode), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tickN(3);
    checkOutput("frozen_sec", 32'(sec), 32'd1);

    // Tick on the SET_MIN->RUN press is discarded and sec cleared.
    pressMode();
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("exit_sec", 32'(sec), 32'd0);
    checkOutput("exit_mode", 32'(mode), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // btn_inc ignored in RUN.
    pressInc();
    checkOutput("run_inc_hour", 32'(hour), 32'd0);
    checkOutput("run_inc_min", 32'(min), 32'd0);
    tickN(1);
    checkOutput("run_tick_sec", 32'(sec), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
